// File: rtl/push_debouncer.sv
// Two-flop synchroniser plus per-button debounce FSM for active-low push buttons.
// Optional auto-repeat of o_Press while held: define PUSH_DB_AUTOREPEAT_EN.
module push_debouncer #(
    parameter int N_BTN     = 2,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20,
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [N_BTN-1:0] i_Push,
    output logic [N_BTN-1:0] o_Push,
    output logic [N_BTN-1:0] o_Press
);

    typedef enum logic [1:0] {REL, CNT_P, HELD, CNT_R} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 1 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db
        $error("push_debouncer: DB_CYCLES out of range for CNT_W");
    end
    if (REP_RATE < 1 || REP_RATE > REP_DELAY) begin : g_bad_rep
        $error("push_debouncer: REP_RATE must be in 1..REP_DELAY");
    end

    state_t           state     [N_BTN];
    state_t           state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] sync_1;
    logic [N_BTN-1:0] s_Push;
    logic [N_BTN-1:0] push_nxt;
    logic [N_BTN-1:0] press_nxt;

`ifdef PUSH_DB_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REP_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
    // Reloading partway up makes every later strobe REP_RATE cycles apart.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_RATE);

    logic [REP_W-1:0] rep     [N_BTN];
    logic [REP_W-1:0] rep_nxt [N_BTN];
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_1  <= '1;
            s_Push  <= '1;
            o_Push  <= '1;
            o_Press <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= REL;
                cnt[i]   <= '0;
`ifdef PUSH_DB_AUTOREPEAT_EN
                rep[i]   <= '0;
`endif
            end
        end else begin
            sync_1  <= i_Push;
            s_Push  <= sync_1;
            o_Push  <= push_nxt;
            o_Press <= press_nxt;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
`ifdef PUSH_DB_AUTOREPEAT_EN
                rep[i]   <= rep_nxt[i];
`endif
            end
        end
    end

    // One shared counter per button qualifies both press and release runs.
    always_comb begin
        push_nxt  = o_Push;
        press_nxt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
`ifdef PUSH_DB_AUTOREPEAT_EN
            rep_nxt[i]   = '0;
`endif
            case (state[i])
                REL: begin
                    if (!s_Push[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt[i] = HELD;
                            cnt_nxt[i]   = '0;
                            push_nxt[i]  = 1'b0;
                            press_nxt[i] = 1'b1;
                        end else begin
                            state_nxt[i] = CNT_P;
                            cnt_nxt[i]   = CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt[i] = '0;
                    end
                end
                CNT_P: begin
                    if (s_Push[i]) begin
                        state_nxt[i] = REL;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = HELD;
                        cnt_nxt[i]   = '0;
                        push_nxt[i]  = 1'b0;
                        press_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (s_Push[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt[i] = REL;
                            cnt_nxt[i]   = '0;
                            push_nxt[i]  = 1'b1;
                        end else begin
                            state_nxt[i] = CNT_R;
                            cnt_nxt[i]   = CNT_W'(1);
                        end
                    end else begin
`ifdef PUSH_DB_AUTOREPEAT_EN
                        if (rep[i] == REP_LAST) begin
                            press_nxt[i] = 1'b1;
                            rep_nxt[i]   = REP_RELOAD;
                        end else begin
                            rep_nxt[i] = rep[i] + REP_W'(1);
                        end
`endif
                    end
                end
                CNT_R: begin
                    if (!s_Push[i]) begin
                        state_nxt[i] = HELD;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = REL;
                        cnt_nxt[i]   = '0;
                        push_nxt[i]  = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = REL;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_debouncer.sv
// Self-checking bench for push_debouncer: directed scenarios plus random bouncing,
// all compared against a run-length reference model of the debouncer.
module tb_push_debouncer;

    localparam int N_BTN     = 2;
    localparam int DB        = 4;
    localparam int REP_DELAY = 10;
    localparam int REP_RATE  = 3;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Push = 2'b11;
    logic [1:0] o_Push;
    logic [1:0] o_Press;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 2-cycle input delay, then a button flips once its
    // delayed input has disagreed with the output for DB consecutive cycles.
    logic [1:0] m_s1, m_s2, m_out, m_press;
    int         m_run  [2];
    int         m_hold [2];

    always #5 i_Clk = ~i_Clk;

    push_debouncer #(
        .N_BTN(N_BTN), .DB_CYCLES(DB), .CNT_W(20),
        .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Push(i_Push),
        .o_Push(o_Push), .o_Press(o_Press)
    );

    task automatic tick();
        @(posedge i_Clk);
        if (i_Rst) begin
            m_s1 = '1; m_s2 = '1; m_out = '1; m_press = '0;
            for (int b = 0; b < 2; b++) begin m_run[b] = 0; m_hold[b] = 0; end
        end else begin
            for (int b = 0; b < 2; b++) begin
                m_press[b] = 1'b0;
                if (m_s2[b] != m_out[b]) begin
                    m_run[b]++;
                    m_hold[b] = 0;
                    if (m_run[b] == DB) begin
                        m_out[b] = m_s2[b];
                        m_run[b] = 0;
                        if (m_s2[b] == 1'b0) m_press[b] = 1'b1;
                    end
                end else begin
                    if (m_out[b] == 1'b0 && m_run[b] == 0) begin
                        m_hold[b]++;
`ifdef PUSH_DB_AUTOREPEAT_EN
                        if (m_hold[b] >= REP_DELAY && (m_hold[b] - REP_DELAY) % REP_RATE == 0)
                            m_press[b] = 1'b1;
`endif
                    end else begin
                        m_hold[b] = 0;
                    end
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = i_Push;
        end
        #1;
    endtask

    task automatic test_reset();
        i_Rst = 1'b1; i_Push = 2'b00;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++;
            if ({o_Push, o_Press} !== 4'b1100) begin
                n_fail++;
                $display("[TB] FAIL reset_state edge %0d: got push=%b press=%b, want 11/00", k, o_Push, o_Press);
            end
        end
        i_Rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (o_Push !== ((k >= 6) ? 2'b00 : 2'b11) || o_Press !== ((k == 6) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("[TB] FAIL reset_release edge %0d: got push=%b press=%b", k, o_Push, o_Press);
            end
        end
        i_Push = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL reset_unpress edge %0d: got %b/%b want %b/%b", k, o_Push, o_Press, m_out, m_press);
            end
        end
    endtask

    task automatic test_clean_press();
        i_Push = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (o_Push !== ((k >= 6) ? 2'b01 : 2'b11) || o_Press !== ((k == 6) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("[TB] FAIL clean_press edge %0d: got push=%b press=%b", k, o_Push, o_Press);
            end
        end
        i_Push = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL clean_release edge %0d: got %b/%b want %b/%b", k, o_Push, o_Press, m_out, m_press);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [15] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 15; k++) begin
            i_Push = {1'b1, pat[k]};
            tick();
            n_checks++;
            if (o_Push[0] !== 1'b1 || o_Press[0] !== 1'b0 || {o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL bounce cycle %0d: got push=%b press=%b", k, o_Push, o_Press);
            end
        end
    endtask

    task automatic test_back_to_back();
        i_Push = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if ({o_Push, o_Press} !== {m_out, m_press} || (k == 6 && o_Press !== 2'b11)) begin
                n_fail++;
                $display("[TB] FAIL both_press edge %0d: got %b/%b want %b/%b", k, o_Push, o_Press, m_out, m_press);
            end
        end
        i_Push = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (o_Push !== ((k >= 6) ? 2'b11 : 2'b00) || {o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL both_release edge %0d: got %b/%b want %b/%b", k, o_Push, o_Press, m_out, m_press);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_Push = 2'b10;
        repeat (5) tick();
        i_Rst = 1'b1;
        tick();
        n_checks++;
        if ({o_Push, o_Press} !== 4'b1100) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got push=%b press=%b, want 11/00", o_Push, o_Press);
        end
        i_Rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (o_Push !== ((k >= 6) ? 2'b10 : 2'b11) || o_Press !== ((k == 6) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_accept edge %0d: got push=%b press=%b", k, o_Push, o_Press);
            end
        end
        i_Push = 2'b11;
        repeat (8) tick();
    endtask

`ifdef PUSH_DB_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int j;
        logic want;
        i_Push = 2'b01;
        for (int k = 1; k <= 36; k++) begin
            tick();
            j = k - 6;
            want = (j == 0) || (j >= 10 && (j - 10) % 3 == 0);
            n_checks++;
            if (o_Press !== {want, 1'b0} || {o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL autorepeat edge %0d: got press=%b want %b", k, o_Press, {want, 1'b0});
            end
        end
        i_Push = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ((k >= 3 && o_Press !== 2'b00) || {o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL autorepeat_stop edge %0d: got press=%b", k, o_Press);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 4) == 0) i_Push[b] = ~i_Push[b];
            i_Rst = ($urandom_range(0, 149) == 0);
            tick();
            n_checks++;
            if ({o_Push, o_Press} !== {m_out, m_press}) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %b/%b want %b/%b", k, o_Push, o_Press, m_out, m_press);
            end
        end
        i_Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
`ifdef PUSH_DB_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/push_debouncer.md
Name: push_debouncer

Overview:
- Upstream conditioning stage for the board push buttons: synchronises raw, bouncing, active-low buttons to i_Clk (50 MHz) and debounces them.
- o_Push feeds the up/down counter's i_Push directly, as clean active-low levels; the counter does its own edge detection.
- o_Press gives a one-cycle press strobe for other consumers.
- Per-button 4-state FSM plus a shared-width stability counter per button.

Parameters:
- N_BTN, 2, number of buttons (bit 1 = up, bit 0 = down, matching counter ordering).
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of each stability counter.
- REP_DELAY, 25000000, hold time before the first auto-repeat strobe (optional feature only).
- REP_RATE, 5000000, interval between subsequent auto-repeat strobes (optional feature only).

Ports:
- i_Clk  input  1  system clock, 50 MHz
- i_Rst  input  1  reset; synchronous, active-high
- i_Push  input  N_BTN  raw buttons, asynchronous, active-low (0 = pressed)
- o_Push  output  N_BTN  debounced level, active-low, registered
- o_Press  output  N_BTN  one-cycle strobe, active-high, on accepted press

Behaviour:
Reset:
- Synchronous on any i_Clk edge with i_Rst=1.
- Sync flops = 1; o_Push = all 1 (released); o_Press = 0; counters = 0; every FSM = REL.
- Reset mid-count or mid-hold discards all progress; outputs reach reset values at that same edge.

Synchronisation:
- Two flops per bit; s_Push = second stage.
- All decisions use s_Push only.

FSM per button, states REL, CNT_P, HELD, CNT_R:
- REL (o_Push=1): s_Push=0 -> CNT_P, cnt=1; else stay, cnt=0.
- CNT_P: s_Push=1 -> REL, cnt=0 (glitch rejected). s_Push=0 and cnt==DB_CYCLES-1 -> HELD, o_Push<=0, o_Press<=1 for that one cycle. Otherwise cnt+1.
- HELD (o_Push=0): s_Push=1 -> CNT_R, cnt=1; else stay.
- CNT_R: s_Push=0 -> HELD, cnt=0. s_Push=1 and cnt==DB_CYCLES-1 -> REL, o_Push<=1, no strobe. Otherwise cnt+1.
- DB_CYCLES=1: the transition occurs on the first mismatching s_Push cycle.

Timing:
- Latency from a clean raw input step to the o_Push change is exactly DB_CYCLES+2 edges: 2 sync + DB_CYCLES stability.
- Any bounce with a run shorter than DB_CYCLES restarts the count; o_Push never toggles on it.
- o_Press is high only in the cycle where o_Push first shows 0; it is 0 at all other times.

Other rules:
- Buttons are fully independent; simultaneous presses produce simultaneous strobes. Arbitration belongs downstream.
- The counter never exceeds DB_CYCLES-1, so no wrap can occur. The counter is shared per button between press and release qualification.

Optional Feature:
- Macro PUSH_DB_AUTOREPEAT_EN.
- Defined: a second counter (width sized to REP_DELAY) runs in HELD. o_Press pulses once REP_DELAY cycles after entering HELD, then every REP_RATE cycles while still in HELD.
- The repeat counter clears when leaving HELD, including on a move to CNT_R. A return CNT_R->HELD does not re-strobe and restarts the repeat delay.
- o_Push is unaffected.
- Undefined: no repeat logic is built; o_Press fires exactly once per accepted press.

Test Plan (bench params DB_CYCLES=4, REP_DELAY=10, REP_RATE=3):
- Reset: i_Rst=1 for 2 edges with i_Push=2'b00 -> o_Push=2'b11, o_Press=0; after release, o_Push=2'b00 at edge 6.
- Clean press: i_Push[1] 1->0 and held -> o_Push[1]=0 exactly 6 edges later; o_Press=2'b10 for one cycle only.
- Bounce: i_Push[0] pattern 0,0,1,0,0,0,1 (one value per cycle), then 1 -> o_Push[0] stays 1 and o_Press[0] stays 0 throughout.
- Release and both buttons: both pressed together, held 20 cycles, then released -> simultaneous o_Press=2'b11 pulse; o_Push returns to 2'b11 6 edges after release with no strobe.
- Reset mid-count: press, assert i_Rst at cycle 3 of CNT_P, continue holding -> o_Push=1; press then accepted 6 edges after i_Rst deasserts.
- With PUSH_DB_AUTOREPEAT_EN: hold i_Push[1]=0 for 30 cycles after acceptance -> o_Press[1] pulses at +0, +10, +13, +16, ... and stops on release.
